// File: rtl/mult_result_stage.sv
// rtl/mult_result_stage.sv - 64-bit product assembly, 2-entry result queue, optional 32-bit beat serializer
module mult_result_stage #(
    parameter int CPA_W = 62,
    parameter int LSB_W = 2,
    parameter int OUT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CPA_W-1:0] in_sum,
    input  logic             in_cout,
    input  logic [LSB_W-1:0] in_lsb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             err_cout,
    input  logic             err_clr,
    output logic [15:0]      count
);
    localparam int P_W = CPA_W + LSB_W;

    logic [P_W-1:0] mem [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     occ;
    logic           push;
    logic           pop;
    logic           beat_hs;
    logic [P_W-1:0] head;

    // in_ready looks only at registered occupancy so out_ready never reaches it
    assign in_ready  = !rst && (occ != 2'd2);
    assign push      = in_valid && in_ready;
    assign out_valid = (occ != 2'd0);
    assign beat_hs   = out_valid && out_ready;
    assign pop       = beat_hs && out_last;
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_sum, in_lsb};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
            occ    <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    // a new carry error outranks a clear landing in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cout <= 1'b0;
        end else if (push && in_cout) begin
            err_cout <= 1'b1;
        end else if (err_clr) begin
            err_cout <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 16'd0;
        end else if (pop) begin
            count <= count + 16'd1;
        end
    end

    generate
        if (OUT_W == 32) begin : g_ser
            logic phase;

            // phase 0 sends the low half, phase 1 the high half and retires the head
            always_ff @(posedge clk) begin
                if (rst) begin
                    phase <= 1'b0;
                end else if (beat_hs) begin
                    phase <= ~phase;
                end
            end

            assign out_last = out_valid && phase;
            assign out_data = !out_valid ? '0 :
                              (phase ? head[P_W-1:OUT_W] : head[OUT_W-1:0]);
        end else begin : g_par
            assign out_last = out_valid;
            assign out_data = out_valid ? head : '0;
        end
    endgenerate

endmodule

// File: doc/mult_result_stage.md
# mult_result_stage

Output stage of the 32x32 unsigned multiplier, directly downstream of the 62-bit carry-propagate adder. It assembles the CPA sum and the two low product bits that bypass the CPA into the 64-bit product. Results are buffered in a 2-entry queue behind a valid/ready handshake and optionally serialized into two 32-bit beats. It also flags any illegal CPA carry-out and counts delivered products.

## Interface
Parameters:
- CPA_W, 62: width of the CPA sum input.
- LSB_W, 2: width of the low product bits that bypass the CPA. P_W = CPA_W + LSB_W = 64.
- OUT_W, 64: output beat width. Legal values are 64 (one beat per product) or 32 (two beats per product).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream product available.
- in_ready  out  1  stage can accept a product.
- in_sum  in  CPA_W  CPA sum, which becomes product bits [63:2].
- in_cout  in  1  CPA carry-out; must be 0 for a legal unsigned 32x32 product.
- in_lsb  in  LSB_W  product bits [1:0].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  OUT_W  output beat.
- out_last  out  1  final beat of the current product.
- err_cout  out  1  sticky flag: a product was accepted with in_cout=1.
- err_clr  in  1  clears err_cout.
- count  out  16  number of products fully delivered; wraps.

## Operation
- Product assembly: product = {in_sum, in_lsb}, 64 bits. in_cout is not part of the stored data.
- Queue:
  - 2-entry FIFO with registered occupancy occ (0..2).
  - in_ready = !rst && (occ < 2). in_ready does not depend on out_ready.
  - Push on in_valid && in_ready. Pop on the handshake (out_valid && out_ready) of a beat with out_last=1.
  - Push and pop in the same cycle are allowed at occ=1; occ stays 1 and order is preserved.
  - Push at occ=2 cannot happen because in_ready=0.
- Output, OUT_W=64:
  - out_valid = (occ > 0).
  - out_data = head product.
  - out_last = 1 whenever out_valid=1.
- Output, OUT_W=32: a phase bit (LO=0, HI=1) drives the serializer.
  - LO state: out_data = head[31:0], out_last = 0. A handshake moves to HI; no pop.
  - HI state: out_data = head[63:32], out_last = 1. A handshake pops the head and returns to LO.
  - The phase only changes on a handshake. Holding out_ready=0 keeps out_data and out_last stable.
- When out_valid=0: out_data = 0 and out_last = 0.
- err_cout:
  - Set on a push with in_cout=1.
  - Cleared by err_clr=1.
  - If set and clear happen in the same cycle, set wins.
- count: increments by 1 on each pop. 0xFFFF wraps to 0x0000.

## Timing
- Reset state (while rst=1 and in the cycle after its release edge):
  - occ=0, phase=LO, err_cout=0, count=0.
  - out_valid=0, out_data=0, out_last=0.
  - in_ready=0 while rst=1; in_ready=1 from the first cycle with rst=0.
- Reset asserted mid-operation:
  - Buffered products and any partially sent product are discarded.
  - No out_valid appears in the cycle after the reset edge.
- Latency: a product pushed at edge k is presented with out_valid=1 after edge k, provided the queue was empty and the phase was LO.
- Throughput with out_ready held at 1:
  - OUT_W=64: one product per cycle.
  - OUT_W=32: one product every 2 cycles.
- Backpressure: with out_ready=0 the queue fills to 2 entries, then in_ready=0 in the following cycle. in_ready returns to 1 the cycle after the first pop.
- No combinational path from in_valid/in_sum to any output port, or from out_ready to in_ready.

## Test plan
- Reset then one product, OUT_W=64: in_sum=0x3FFFFFFF80000000, in_lsb=2'b01, out_ready=1 -> one cycle later out_data=0xFFFFFFFE00000001, out_last=1; count=1 after the handshake; err_cout=0.
- OUT_W=32, same product, out_ready=1 -> out_data=0x00000001 with out_last=0, then 0xFFFFFFFE with out_last=1; count=1.
- Backpressure: push 3 products 0x1, 0x2, 0x3 back-to-back with out_ready=0 -> in_ready drops after 2 pushes and the 3rd is held. Releasing out_ready gives output order 0x1, 0x2, 0x3, and in_ready=1 again after the first pop.
- Carry error: push with in_cout=1 -> err_cout=1 next cycle and the data is still delivered. err_clr=1 coincident with a new in_cout=1 push -> err_cout stays 1. err_clr alone -> err_cout=0.
- Reset mid-stream: OUT_W=32, assert rst after the LO beat of a product with the queue holding 2 entries -> out_valid=0 and count=0 after reset; the next product starts with its LO beat.
- Counter wrap: force 65536 deliveries with out_ready=1 -> count reads 0xFFFF then 0x0000, with no out_valid gaps at OUT_W=64.
